// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch/execute side bundle for the branch target buffer
interface branch_target_buffer_if;
  logic [31:0] btb_lookup_pc_i;
  logic        btb_update_i;
  logic [31:0] btb_update_pc_i;
  logic        btb_update_taken_i;
  logic [31:0] btb_update_target_i;
  logic        btb_flush_i;
  logic        btb_hit_o;
  logic        btb_br_pred_o;
  logic [31:0] btb_pred_target_addr_o;
  logic [15:0] btb_mispredict_cnt_o;

  modport master (
    output btb_lookup_pc_i, btb_update_i, btb_update_pc_i, btb_update_taken_i,
           btb_update_target_i, btb_flush_i,
    input  btb_hit_o, btb_br_pred_o, btb_pred_target_addr_o, btb_mispredict_cnt_o
  );

  modport slave (
    input  btb_lookup_pc_i, btb_update_i, btb_update_pc_i, btb_update_taken_i,
           btb_update_target_i, btb_flush_i,
    output btb_hit_o, btb_br_pred_o, btb_pred_target_addr_o, btb_mispredict_cnt_o
  );
endinterface

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with 2-bit counters and mispredict counter
module branch_target_buffer #(
  parameter int IDX_BITS = 4
) (
  input logic                  clk,
  input logic                  rst,
  branch_target_buffer_if.slave btb
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [15:0]         mis_cnt_q, mis_cnt_d;

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  logic                lk_hit, up_hit, up_pred;

  logic                ent_we, ent_valid_d;
  logic [TAG_W-1:0]    ent_tag_d;
  logic [31:0]         ent_target_d;
  logic [1:0]          ent_ctr_d;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^{btb.btb_lookup_pc_i[1:0], btb.btb_update_pc_i[1:0]};

  assign lk_idx = btb.btb_lookup_pc_i[IDX_BITS+1:2];
  assign lk_tag = btb.btb_lookup_pc_i[31:IDX_BITS+2];
  assign up_idx = btb.btb_update_pc_i[IDX_BITS+1:2];
  assign up_tag = btb.btb_update_pc_i[31:IDX_BITS+2];

  // Lookup reads registered state only, so a same-cycle update is never bypassed.
  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_pred = up_hit && ctr_q[up_idx][1];

  assign btb.btb_hit_o              = lk_hit;
  assign btb.btb_br_pred_o          = lk_hit && ctr_q[lk_idx][1];
  assign btb.btb_pred_target_addr_o = lk_hit ? target_q[lk_idx] : 32'd0;
  assign btb.btb_mispredict_cnt_o   = mis_cnt_q;

  always_comb begin
    ent_we       = 1'b0;
    ent_valid_d  = valid_q[up_idx];
    ent_tag_d    = tag_q[up_idx];
    ent_target_d = target_q[up_idx];
    ent_ctr_d    = ctr_q[up_idx];
    mis_cnt_d    = mis_cnt_q;

    if (btb.btb_update_i && (up_pred != btb.btb_update_taken_i) && (mis_cnt_q != 16'hFFFF))
      mis_cnt_d = mis_cnt_q + 16'd1;

    // Flush wins over a simultaneous update; only the mispredict count still moves.
    if (btb.btb_update_i && !btb.btb_flush_i) begin
      if (up_hit) begin
        ent_we = 1'b1;
        if (btb.btb_update_taken_i) begin
          ent_ctr_d    = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
          ent_target_d = btb.btb_update_target_i;
        end else begin
          ent_ctr_d = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
        end
      end else if (btb.btb_update_taken_i) begin
        ent_we       = 1'b1;
        ent_valid_d  = 1'b1;
        ent_tag_d    = up_tag;
        ent_target_d = btb.btb_update_target_i;
        ent_ctr_d    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
      mis_cnt_q <= 16'd0;
    end else begin
      mis_cnt_q <= mis_cnt_d;
      if (btb.btb_flush_i) begin
        for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end else if (ent_we) begin
        valid_q[up_idx]  <= ent_valid_d;
        tag_q[up_idx]    <= ent_tag_d;
        target_q[up_idx] <= ent_target_d;
        ctr_q[up_idx]    <= ent_ctr_d;
      end
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - directed and randomized checks of branch_target_buffer against a reference model
module tb_branch_target_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  branch_target_buffer_if bus ();

  branch_target_buffer #(.IDX_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .btb (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: table indexed by word address modulo 16, tag is the rest of the address.
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  int unsigned m_target [16];
  int          m_ctr    [16];
  int          m_cnt;

  function automatic int m_idx(input int unsigned pc);
    return (pc / 4) % 16;
  endfunction

  function automatic int unsigned m_tagof(input int unsigned pc);
    return pc / 64;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    m_cnt = 0;
  endtask

  task automatic model_lookup(input int unsigned pc, output bit h, output bit p, output int unsigned t);
    int i;
    i = m_idx(pc);
    h = m_valid[i] && (m_tag[i] == m_tagof(pc));
    p = h && (m_ctr[i] >= 2);
    t = h ? m_target[i] : 0;
  endtask

  task automatic model_apply(input bit upd, input int unsigned pc, input bit tk,
                             input int unsigned tgt, input bit fl);
    bit h, p; int unsigned t; int i;
    model_lookup(pc, h, p, t);
    i = m_idx(pc);
    if (upd && (p != tk) && (m_cnt < 65535)) m_cnt++;
    if (fl) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 0;
    end else if (upd) begin
      if (h) begin
        if (tk) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_target[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (tk) begin
        m_valid[i] = 1; m_tag[i] = m_tagof(pc); m_target[i] = tgt; m_ctr[i] = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input bit h, input bit p,
                            input int unsigned t, input int unsigned c);
    chk({tag, ".hit"},    {31'd0, bus.btb_hit_o}, {31'd0, h});
    chk({tag, ".pred"},   {31'd0, bus.btb_br_pred_o}, {31'd0, p});
    chk({tag, ".target"}, bus.btb_pred_target_addr_o, t);
    chk({tag, ".count"},  {16'd0, bus.btb_mispredict_cnt_o}, c);
  endtask

  task automatic expect_model(input string tag);
    bit h, p; int unsigned t;
    model_lookup(bus.btb_lookup_pc_i, h, p, t);
    expect_out(tag, h, p, t, m_cnt);
  endtask

  task automatic drive(input bit upd, input int unsigned upc, input bit tk,
                       input int unsigned tgt, input bit fl, input int unsigned lpc);
    bus.btb_update_i        = upd;
    bus.btb_update_pc_i     = upc;
    bus.btb_update_taken_i  = tk;
    bus.btb_update_target_i = tgt;
    bus.btb_flush_i         = fl;
    bus.btb_lookup_pc_i     = lpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst)
      model_apply(bus.btb_update_i, bus.btb_update_pc_i, bus.btb_update_taken_i,
                  bus.btb_update_target_i, bus.btb_flush_i);
    #1;
  endtask

  function automatic int unsigned rand_pc();
    return ($urandom_range(0, 3) * 64) + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
  endfunction

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 32'h40);
    @(posedge clk); #1;
    expect_out("in_reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    drive(0, 0, 0, 0, 0, 32'h40);
    expect_out("after_reset", 0, 0, 0, 0);
    tick();

    drive(1, 32'h40, 1, 32'h100, 0, 32'h40);
    expect_out("alloc_same_cycle", 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 32'h40);
    expect_out("alloc_next", 1, 1, 32'h100, 1);

    drive(1, 32'h40, 0, 0, 0, 32'h40);
    tick();
    drive(0, 0, 0, 0, 0, 32'h40);
    expect_out("nt1_ctr01", 1, 0, 32'h100, 2);
    drive(1, 32'h40, 0, 0, 0, 32'h40);
    tick();
    drive(0, 0, 0, 0, 0, 32'h40);
    expect_out("nt2_ctr00", 1, 0, 32'h100, 2);
    drive(1, 32'h40, 1, 32'h100, 0, 32'h40);
    tick();
    drive(0, 0, 0, 0, 0, 32'h40);
    expect_out("t1_ctr01", 1, 0, 32'h100, 3);
    drive(1, 32'h40, 1, 32'h100, 0, 32'h40);
    tick();
    drive(0, 0, 0, 0, 0, 32'h40);
    expect_out("t2_ctr10", 1, 1, 32'h100, 4);
    drive(1, 32'h40, 1, 32'h108, 0, 32'h40);
    tick();
    drive(0, 0, 0, 0, 0, 32'h40);
    expect_out("t3_ctr11", 1, 1, 32'h108, 4);
    drive(1, 32'h40, 1, 32'h108, 0, 32'h40);
    tick();
    drive(0, 0, 0, 0, 0, 32'h40);
    expect_out("t4_sat11", 1, 1, 32'h108, 4);
    drive(1, 32'h40, 0, 0, 0, 32'h40);
    tick();
    drive(0, 0, 0, 0, 0, 32'h40);
    expect_out("nt_from11", 1, 1, 32'h108, 5);

    drive(1, 32'h440, 1, 32'h200, 0, 32'h40);
    tick();
    drive(0, 0, 0, 0, 0, 32'h40);
    expect_out("alias_old", 0, 0, 0, 6);
    drive(0, 0, 0, 0, 0, 32'h440);
    expect_out("alias_new", 1, 1, 32'h200, 6);

    drive(1, 32'h80, 1, 32'h300, 0, 32'h80);
    expect_out("nobypass", 0, 0, 0, 6);
    tick();
    drive(0, 0, 0, 0, 0, 32'h80);
    expect_out("bypass_next", 1, 1, 32'h300, 7);

    drive(1, 32'hC0, 1, 32'h400, 1, 32'h80);
    tick();
    drive(0, 0, 0, 0, 0, 32'h80);
    expect_out("flush_80", 0, 0, 0, 8);
    drive(0, 0, 0, 0, 0, 32'hC0);
    expect_out("flush_c0", 0, 0, 0, 8);
    drive(0, 0, 0, 0, 0, 32'h440);
    expect_out("flush_440", 0, 0, 0, 8);

    drive(1, 32'h500, 1, 32'h600, 0, 32'h500);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 32'h500);
    expect_out("rst_discard", 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 9) < 7, rand_pc(), $urandom_range(0, 9) < 6,
            $urandom, $urandom_range(0, 19) == 0, rand_pc());
      expect_model($sformatf("rand%0d", n));
      tick();
    end

    for (int n = 0; n < 65536; n++) begin
      drive(1, 32'h1000, 1, 32'h2000, 1, 32'h1000);
      tick();
    end
    drive(0, 0, 0, 0, 0, 32'h1000);
    expect_out("cnt_sat", 0, 0, 0, 32'hFFFF);
    chk("cnt_sat_model", {16'd0, bus.btb_mispredict_cnt_o}, m_cnt);

    #2 rst = 1'b1;
    #1;
    expect_out("async_rst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    model_reset();
    tick();
    expect_out("post_rst", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter IDX_BITS, default 4, meaning log2 of entry count (16 entries, direct-mapped).
REQ-002 clk  input  1  single clock, all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 btb_lookup_pc_i  input  32  current fetch PC from the fetch stage PC register.
REQ-005 btb_update_i  input  1  resolved control-flow instruction reported from execute this cycle.
REQ-006 btb_update_pc_i  input  32  PC of the resolved instruction.
REQ-007 btb_update_taken_i  input  1  actual direction of the resolved instruction.
REQ-008 btb_update_target_i  input  32  actual target of the resolved instruction.
REQ-009 btb_flush_i  input  1  synchronous invalidate of all entries.
REQ-010 btb_hit_o  output  1  lookup PC matches a valid entry.
REQ-011 btb_br_pred_o  output  1  predicted taken (hit and counter MSB set).
REQ-012 btb_pred_target_addr_o  output  32  stored target of the hit entry, 0 on miss.
REQ-013 btb_mispredict_cnt_o  output  16  count of updates where the stored prediction disagreed with the outcome.

Function
REQ-014 Index SHALL be PC[IDX_BITS+1:2]; tag SHALL be PC[31:IDX_BITS+2]; PC[1:0] ignored.
REQ-015 Each entry SHALL hold valid, tag, 32-bit target, 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-016 Lookup SHALL be combinational, zero latency: hit = valid and tag match at lookup index.
REQ-017 btb_br_pred_o SHALL equal hit and counter[1]; on miss btb_br_pred_o = 0, target = 0.
REQ-018 On update with hit and taken: counter increments saturating at 11; target overwritten with btb_update_target_i.
REQ-019 On update with hit and not taken: counter decrements saturating at 00; target unchanged; entry stays valid.
REQ-020 On update with miss and taken: entry at index allocated (overwriting any other tag), valid = 1, counter = 10 (WT), target written.
REQ-021 On update with miss and not taken: no state change.
REQ-022 Update SHALL take effect at the next rising edge; a same-cycle lookup of the same index SHALL see pre-update contents (no bypass).
REQ-023 Mispredict SHALL be counted when btb_update_i is asserted and (hit and counter[1]) evaluated on the update PC differs from btb_update_taken_i; a miss counts as predicted not-taken.
REQ-024 btb_mispredict_cnt_o SHALL saturate at 16'hFFFF, never wrap.
REQ-025 btb_flush_i SHALL clear all valid bits at the next edge; counters, targets and mispredict count are unaffected.
REQ-026 Simultaneous flush and update: flush wins, no allocation or counter change; mispredict count still updates.

Reset
REQ-027 While rst is high: all valid = 0, all counters = 01, all targets and tags = 0, mispredict count = 0, asynchronously.
REQ-028 Outputs during and after reset until first allocation: btb_hit_o = 0, btb_br_pred_o = 0, btb_pred_target_addr_o = 0, btb_mispredict_cnt_o = 0.
REQ-029 Reset asserted mid-operation SHALL discard any in-flight update at that edge.

Verification
REQ-030 Reset then lookup 0x0000_0040 -> hit 0, pred 0, target 0, count 0.
REQ-031 Update pc 0x0000_0040 taken target 0x0000_0100, next cycle lookup 0x40 -> hit 1, pred 1, target 0x100, count 1.
REQ-032 Same PC two not-taken updates -> counter 10->01->00, pred 0, hit 1; two further taken updates -> 01 then 10, pred 1; 11 after third, fourth stays 11.
REQ-033 Aliasing: 0x40 allocated, then taken update 0x0000_0440 (same index) target 0x200 -> lookup 0x40 miss, lookup 0x440 hit target 0x200.
REQ-034 Update and lookup of 0x80 in same cycle on empty entry -> lookup that cycle miss, next cycle hit; flush with simultaneous update of 0xC0 -> all lookups miss afterwards.
REQ-035 Drive 65536 mispredicting updates -> count holds 0xFFFF; async rst pulse between edges -> count 0 immediately.
